anna_fetch_decode: RTL and testbench

- Instruction fetch and decode front end for the ANNA 16-bit core.
- Holds the architectural PC and fetches one instruction word per instruction from instruction memory over a req/ack handshake.
- Splits each word into opcode/func/rd/rs1/rs2/imm6/imm8 fields and presents them to the ALU with a valid/ready handshake.
- Waits for the ALU's next-PC value before starting the next fetch. Strictly one instruction in flight, no speculation.

---
 rtl/anna_pkg.sv | 49 ++++
 rtl/anna_instr_fields.sv | 26 ++
 rtl/anna_fetch_decode.sv | 114 +++++++++++
 tb/tb_anna_fetch_decode.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/anna_pkg.sv
// Shared ANNA front-end definitions: opcodes, func codes, field positions
// and the fetch state type.
package anna_pkg;

    localparam logic [3:0] OP_MATH = 4'h0;
    localparam logic [3:0] OP_JALR = 4'h1;
    localparam logic [3:0] OP_IN   = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SHF  = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_LLI  = 4'h8;
    localparam logic [3:0] OP_LUI  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'ha;
    localparam logic [3:0] OP_BNE  = 4'hb;
    localparam logic [3:0] OP_BGT  = 4'hc;
    localparam logic [3:0] OP_BGE  = 4'hd;
    localparam logic [3:0] OP_BLT  = 4'he;
    localparam logic [3:0] OP_BLE  = 4'hf;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_AND = 3'd2;
    localparam logic [2:0] FUNC_OR  = 3'd3;
    localparam logic [2:0] FUNC_NOT = 3'd4;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS1_HI  = 8;
    localparam int RS1_LO  = 6;
    localparam int RS2_HI  = 5;
    localparam int RS2_LO  = 3;
    localparam int FUNC_HI = 2;
    localparam int FUNC_LO = 0;
    localparam int IMM6_HI = 5;
    localparam int IMM8_HI = 7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_PC,
        S_HALTED
    } fetch_state_e;

endpackage

// File: rtl/anna_instr_fields.sv
// Combinational slicer from an ANNA instruction word to its fields,
// plus the .halt (OUT with rd == r0) detector.
module anna_instr_fields
    import anna_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [2:0]  func,
    output logic [5:0]  imm6,
    output logic [7:0]  imm8,
    output logic        is_halt
);

    assign opcode  = instr[OPC_HI:OPC_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign rs1     = instr[RS1_HI:RS1_LO];
    assign rs2     = instr[RS2_HI:RS2_LO];
    assign func    = instr[FUNC_HI:FUNC_LO];
    assign imm6    = instr[IMM6_HI:0];
    assign imm8    = instr[IMM8_HI:0];
    assign is_halt = (opcode == OP_OUT) && (rd == 3'd0);

endmodule

// File: rtl/anna_fetch_decode.sv
// ANNA fetch/decode front end: one instruction in flight, PC from the ALU.
// Optional trap on IN / OUT rd!=0 with macro ANNA_DECODE_ILLEGAL_TRAP_EN.
module anna_fetch_decode
    import anna_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_SIZE-1:0]  imem_rdata,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [3:0]            opcode,
    output logic [2:0]            rd,
    output logic [2:0]            rs1,
    output logic [2:0]            rs2,
    output logic [2:0]            func,
    output logic [5:0]            imm6,
    output logic [7:0]            imm8,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  halt,
    output logic                  illegal
);

    fetch_state_e          state;
    fetch_state_e          state_nx;
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_SIZE-1:0]  ir;
    logic                  run;
    logic                  halt_q;
    logic                  is_halt;
    logic                  trap;
    logic                  ack_ok;

    anna_instr_fields u_fields (
        .instr   (ir[15:0]),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .func    (func),
        .imm6    (imm6),
        .imm8    (imm8),
        .is_halt (is_halt)
    );

`ifdef ANNA_DECODE_ILLEGAL_TRAP_EN
    logic illegal_q;

    assign trap = (opcode == OP_IN) || ((opcode == OP_OUT) && (rd != 3'd0));
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && !is_halt && trap) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
    assign illegal = 1'b0;
`endif

    // run stays low for the first cycle after reset so a stale ack is dropped
    assign ack_ok    = run && imem_ack;
    assign imem_req  = run && (state == S_FETCH);
    assign imem_addr = pc;
    assign dec_valid = (state == S_ISSUE);
    assign pc_out    = pc;
    assign halt      = halt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            run    <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            if (state == S_FETCH && ack_ok) begin
                ir <= imem_rdata;
            end
            if (state == S_WAIT_PC && pc_load) begin
                pc <= pc_load_value;
            end
            if (state == S_DECODE && is_halt) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:   if (ack_ok) state_nx = S_DECODE;
            S_DECODE:  state_nx = (is_halt || trap) ? S_HALTED : S_ISSUE;
            S_ISSUE:   if (dec_ready) state_nx = S_WAIT_PC;
            S_WAIT_PC: if (pc_load) state_nx = S_FETCH;
            S_HALTED:  state_nx = S_HALTED;
            default:   state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_anna_fetch_decode.sv
// Directed plus randomized bench for anna_fetch_decode against an
// arithmetic field/behaviour model.
module tb_anna_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2, func;
    logic [5:0]  imm6;
    logic [7:0]  imm8;
    logic [15:0] pc_out;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0;
    logic        halt;
    logic        illegal;

`ifdef ANNA_DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] mpc = 16'h0;
    bit stopped;

    anna_fetch_decode dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func(func), .imm6(imm6), .imm8(imm8),
        .pc_out(pc_out), .pc_load(pc_load),
        .pc_load_value(pc_load_value),
        .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input int w);
        check("opcode", 32'(opcode), 32'(w / 4096));
        check("rd",     32'(rd),     32'((w / 512) % 8));
        check("rs1",    32'(rs1),    32'((w / 64) % 8));
        check("rs2",    32'(rs2),    32'((w / 8) % 8));
        check("func",   32'(func),   32'(w % 8));
        check("imm6",   32'(imm6),   32'(w % 64));
        check("imm8",   32'(imm8),   32'(w % 256));
    endtask

    task automatic check_reset_outputs();
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(dec_valid), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_pc_out", 32'(pc_out), 0);
        check("rst_halt", 32'(halt), 0);
        check("rst_illegal", 32'(illegal), 0);
        check_fields(0);
    endtask

    task automatic do_reset(input bit stale_ack);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        mpc = 16'h0;
        if (stale_ack) begin
            imem_ack = 1'b1;
            imem_rdata = 16'hffff;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        check("post_rst_req", 32'(imem_req), 1);
        check("post_rst_valid", 32'(dec_valid), 0);
        check_fields(0);
    endtask

    task automatic run_instr(input int w, input int ack_dly, input int rdy_dly,
                             input bit spurious, input logic [15:0] nxt);
        int n;
        bit is_halt, is_trap;
        is_halt = (w / 4096 == 3) && ((w / 512) % 8 == 0);
        is_trap = TRAP && !is_halt &&
                  ((w / 4096 == 2) || (w / 4096 == 3 && (w / 512) % 8 != 0));
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_rise", 32'(imem_req), 1);
        check("addr", 32'(imem_addr), 32'(mpc));
        repeat (ack_dly) begin
            @(negedge clk);
            check("req_hold", 32'(imem_req), 1);
        end
        imem_ack = 1'b1;
        imem_rdata = 16'(w);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 16'($urandom);
        check("req_drop", 32'(imem_req), 0);
        check_fields(w);
        @(negedge clk);
        stopped = is_halt || is_trap;
        if (stopped) begin
            check("halt_flag", 32'(halt), 32'(is_halt));
            check("illegal_flag", 32'(illegal), 32'(is_trap));
            repeat (10) begin
                check("stop_valid", 32'(dec_valid), 0);
                check("stop_req", 32'(imem_req), 0);
                @(negedge clk);
            end
            return;
        end
        check("valid", 32'(dec_valid), 1);
        check("pc_out", 32'(pc_out), 32'(mpc));
        check("illegal_low", 32'(illegal), 0);
        check("halt_low", 32'(halt), 0);
        repeat (rdy_dly) begin
            if (spurious) begin
                pc_load = 1'b1;
                pc_load_value = 16'($urandom);
            end
            @(negedge clk);
            pc_load = 1'b0;
            check("valid_hold", 32'(dec_valid), 1);
            check("pc_out_hold", 32'(pc_out), 32'(mpc));
            check_fields(w);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        check("valid_drop", 32'(dec_valid), 0);
        check("wait_req", 32'(imem_req), 0);
        pc_load = 1'b1;
        pc_load_value = nxt;
        @(negedge clk);
        pc_load = 1'b0;
        mpc = nxt;
        check("next_req", 32'(imem_req), 1);
        check("next_addr", 32'(imem_addr), 32'(mpc));
    endtask

    initial begin
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(32'h0a50, 2, 0, 1'b0, 16'h0002);
        run_instr(32'h8780, 0, 3, 1'b1, 16'h1234);

        for (int i = 0; i < 16; i++) begin
            run_instr(int'($urandom_range(0, 16'hffff)),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b1,
                      16'($urandom));
            if (stopped) do_reset(1'b0);
        end

        do_reset(1'b1);
        run_instr(32'h4a45, 1, 1, 1'b0, 16'hfffe);

        run_instr(32'h2200, 0, 0, 1'b0, 16'h0040);
        if (stopped) do_reset(1'b0);

        run_instr(32'h3000, 1, 0, 1'b0, 16'h0000);
        check("final_halt", 32'(halt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
